// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD initiator: operand width, FSM state encoding and
// the queued request record.
package gcd_pkg;

    localparam int GCD_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        DRAIN,
        RESP
    } gcd_master_state_t;

    typedef struct packed {
        logic [GCD_WIDTH-1:0] a;
        logic [GCD_WIDTH-1:0] b;
    } gcd_req_t;

    // The engine must never see a zero operand, so such pairs are answered locally.
    function automatic logic has_zero_operand(input gcd_req_t r);
        return (r.a == '0) || (r.b == '0);
    endfunction

endpackage

// File: rtl/gcd_master_if.sv
// Request stream, response stream and engine handshake of the GCD initiator.
// The master modport is the initiator's view; slave is the view of its environment.
interface gcd_master_if #(
    parameter int WIDTH = 16
);

    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;

    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_gcd;
    logic             resp_err;

    logic             Begin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             Complete;
    logic [WIDTH-1:0] gcd;

    modport master (
        input  req_valid, req_a, req_b, resp_ready, Complete, gcd,
        output req_ready, resp_valid, resp_gcd, resp_err, Begin, a, b
    );

    modport slave (
        output req_valid, req_a, req_b, resp_ready, Complete, gcd,
        input  req_ready, resp_valid, resp_gcd, resp_err, Begin, a, b
    );

endinterface

// File: rtl/gcd_req_fifo.sv
// Synchronous request FIFO of gcd_req_t. Pointers carry one extra wrap bit so that
// full and empty are distinguished without a separate occupancy counter.
module gcd_req_fifo
    import gcd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     i_push,
    input  gcd_req_t i_wr_data,
    input  logic     i_pop,
    output gcd_req_t o_rd_data,
    output logic     o_full,
    output logic     o_empty
);

    localparam int AW = $clog2(DEPTH);

    gcd_req_t      r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic          w_push;
    logic          w_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    // A full queue refuses a push even when the same cycle pops.
    assign w_push    = i_push && !o_full;
    assign w_pop     = i_pop && !o_empty;
    assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

    // NOTE: clocked state is written only with <= so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // NOTE: storage has no reset; the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end

endmodule

// File: rtl/gcd_master.sv
// GCD initiator: queues operand pairs, runs one engine job at a time and returns
// results in request order. Define GCD_MASTER_TIMEOUT_EN to build the completion watchdog.
module gcd_master
    import gcd_pkg::*;
#(
    parameter int WIDTH          = GCD_WIDTH,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic          clk,
    input logic          rst,
    gcd_master_if.master bus
);

    if (WIDTH != GCD_WIDTH || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
        TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("gcd_master: unsupported WIDTH/DEPTH/TIMEOUT_CYCLES");
    end

    gcd_master_state_t r_state;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic              r_begin;
    logic              r_resp_valid;
    logic [WIDTH-1:0]  r_resp_gcd;

    gcd_req_t          w_req;
    gcd_req_t          w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;

    assign w_req.a = bus.req_a;
    assign w_req.b = bus.req_b;

    // Never pop while Complete is high: that also absorbs a completion left over from
    // a job that was cut short by reset.
    assign w_pop = (r_state == IDLE) && !w_empty && !bus.Complete;

    gcd_req_fifo #(
        .DEPTH (DEPTH)
    ) u_req_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (bus.req_valid),
        .i_wr_data (w_req),
        .i_pop     (w_pop),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    assign bus.req_ready  = !w_full;
    assign bus.Begin      = r_begin;
    assign bus.a          = r_a;
    assign bus.b          = r_b;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_gcd   = r_resp_gcd;

`ifdef GCD_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_resp_err;
    logic             w_expired;

    // The count includes the Begin cycle, so expiry lands TIMEOUT_CYCLES after Begin.
    assign w_expired    = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign bus.resp_err = r_resp_err;
`else
    assign bus.resp_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_a          <= '0;
            r_b          <= '0;
            r_begin      <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_gcd   <= '0;
`ifdef GCD_MASTER_TIMEOUT_EN
            r_cnt        <= '0;
            r_resp_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_a <= w_head.a;
                        r_b <= w_head.b;
                        if (has_zero_operand(w_head)) begin
                            r_resp_gcd   <= w_head.a | w_head.b;
                            r_resp_valid <= 1'b1;
                            r_state      <= RESP;
                        end else begin
                            r_begin <= 1'b1;
                            r_state <= ISSUE;
`ifdef GCD_MASTER_TIMEOUT_EN
                            r_cnt   <= '0;
`endif
                        end
                    end
                end

                ISSUE: begin
                    r_begin <= 1'b0;
                    r_state <= WAIT_DONE;
`ifdef GCD_MASTER_TIMEOUT_EN
                    r_cnt   <= r_cnt + CNT_W'(1);
`endif
                end

                WAIT_DONE: begin
                    if (bus.Complete) begin
                        r_resp_gcd <= bus.gcd;
                        r_state    <= DRAIN;
                    end
`ifdef GCD_MASTER_TIMEOUT_EN
                    else if (w_expired) begin
                        r_resp_gcd   <= '0;
                        r_resp_err   <= 1'b1;
                        r_resp_valid <= 1'b1;
                        r_state      <= RESP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
`endif
                end

                // The engine's second Complete cycle is absorbed here.
                DRAIN: begin
                    if (!bus.Complete) begin
                        r_resp_valid <= 1'b1;
                        r_state      <= RESP;
                    end
`ifdef GCD_MASTER_TIMEOUT_EN
                    else if (w_expired) begin
                        r_resp_gcd   <= '0;
                        r_resp_err   <= 1'b1;
                        r_resp_valid <= 1'b1;
                        r_state      <= RESP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
`endif
                end

                RESP: begin
                    if (bus.resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= IDLE;
`ifdef GCD_MASTER_TIMEOUT_EN
                        r_resp_err   <= 1'b0;
`endif
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_master.sv
// Bench for gcd_master: engine model on the Begin/Complete side, directed request
// vectors, and a response scoreboard drained by an independent monitor.
module tb_gcd_master;

    localparam int W       = gcd_pkg::GCD_WIDTH;
    localparam int ENG_LAT = 3;
`ifdef GCD_MASTER_TIMEOUT_EN
    localparam int TO = 64;
`else
    localparam int TO = 1024;
`endif

    typedef struct packed {
        logic [W-1:0] gcd;
        logic         err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gcd_master_if #(.WIDTH(W)) gif ();

    gcd_master #(
        .WIDTH          (W),
        .DEPTH          (4),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (gif)
    );

    int   n_checks   = 0;
    int   n_errors   = 0;
    int   n_begin    = 0;
    int   n_resp     = 0;
    int   n_expected = 0;
    bit   eng_hang   = 1'b0;
    exp_t sb[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] euclid(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] t;
        while (y != '0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Engine model: answers each Begin after ENG_LAT cycles with Complete high for
    // two cycles, and checks that a/b stay put and Begin stays a single pulse.
    logic [W-1:0] ea, eb;
    initial begin
        gif.Complete = 1'b0;
        gif.gcd      = '0;
        forever begin
            @(negedge clk);
            if (!rst && gif.Begin === 1'b1 && !eng_hang) begin
                ea = gif.a;
                eb = gif.b;
                repeat (ENG_LAT) begin
                    @(negedge clk);
                    check("begin_single_pulse", gif.Begin, 0);
                    check("a_hold_wait", gif.a, ea);
                    check("b_hold_wait", gif.b, eb);
                end
                gif.Complete = 1'b1;
                gif.gcd      = euclid(ea, eb);
                repeat (2) begin
                    @(negedge clk);
                    check("a_hold_complete", gif.a, ea);
                    check("b_hold_complete", gif.b, eb);
                end
                gif.Complete = 1'b0;
                gif.gcd      = '0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && gif.Begin === 1'b1) n_begin++;
    end

    // Monitor: a response seen valid and ready here is consumed on the next rising edge.
    always @(negedge clk) begin
        if (!rst && gif.resp_valid === 1'b1 && gif.resp_ready === 1'b1) begin
            n_resp++;
            if (sb.size() == 0) begin
                check("resp_unexpected", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("resp_gcd", gif.resp_gcd, mon_e.gcd);
                check("resp_err", gif.resp_err, mon_e.err);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] pa, input logic [W-1:0] pb,
                        input logic [W-1:0] eg, input logic ee, input bit track);
        int n = 0;
        gif.req_a     = pa;
        gif.req_b     = pb;
        gif.req_valid = 1'b1;
        if (track) begin
            sb.push_back('{gcd: eg, err: ee});
            n_expected++;
        end
        forever begin
            @(negedge clk);
            if (gif.req_ready === 1'b1) break;
            n++;
            if (n > 300) begin
                check("push_accept_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        gif.req_valid = 1'b0;
    endtask

    task automatic wait_begin(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gif.Begin !== 1'b1 && n < 100);
        check(tag, gif.Begin, 1);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check(tag, sb.size(), 0);
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    int nb0;
    int nw;

    initial begin
        rst            = 1'b1;
        gif.req_valid  = 1'b0;
        gif.req_a      = '0;
        gif.req_b      = '0;
        gif.resp_ready = 1'b1;
        repeat (3) step();

        check("rst_begin", gif.Begin, 0);
        check("rst_a", gif.a, 0);
        check("rst_b", gif.b, 0);
        check("rst_resp_valid", gif.resp_valid, 0);
        check("rst_resp_gcd", gif.resp_gcd, 0);
        check("rst_resp_err", gif.resp_err, 0);
        check("rst_req_ready", gif.req_ready, 1);
        rst = 1'b0;
        step();

        // (48,18): Begin in the second cycle after the push, result 2 cycles after Complete.
        nb0 = n_begin;
        push(16'd48, 16'd18, 16'd6, 1'b0, 1'b1);
        @(negedge clk);
        check("lat_begin_early", gif.Begin, 0);
        @(negedge clk);
        check("lat_begin", gif.Begin, 1);
        check("lat_a", gif.a, 48);
        check("lat_b", gif.b, 18);
        nw = 0;
        do begin
            @(negedge clk);
            #2;
            nw++;
        end while (gif.Complete !== 1'b1 && nw < 100);
        check("complete_seen", gif.Complete, 1);
        @(negedge clk);
        check("resp_after_complete_1", gif.resp_valid, 0);
        @(negedge clk);
        check("resp_after_complete_2", gif.resp_valid, 0);
        @(negedge clk);
        check("resp_after_complete_3", gif.resp_valid, 1);
        wait_drain("drain_48_18");
        check("begin_count_48_18", n_begin - nb0, 1);

        // Zero operands bypass the engine.
        nb0 = n_begin;
        push(16'd0, 16'd7, 16'd7, 1'b0, 1'b1);
        @(negedge clk);
        check("zero7_lat_early", gif.resp_valid, 0);
        @(negedge clk);
        check("zero7_lat", gif.resp_valid, 1);
        step();
        push(16'd0, 16'd0, 16'd0, 1'b0, 1'b1);
        @(negedge clk);
        check("zero0_lat_early", gif.resp_valid, 0);
        @(negedge clk);
        check("zero0_lat", gif.resp_valid, 1);
        wait_drain("drain_zero");
        check("zero_no_begin", n_begin - nb0, 0);

        // Back-pressure: one job in flight plus four queued fills the request side.
        gif.resp_ready = 1'b0;
        push(16'd12, 16'd8, 16'd4, 1'b0, 1'b1);
        push(16'd9, 16'd6, 16'd3, 1'b0, 1'b1);
        push(16'd35, 16'd21, 16'd7, 1'b0, 1'b1);
        push(16'd17, 16'd5, 16'd1, 1'b0, 1'b1);
        check("ready_before_5th", gif.req_ready, 1);
        push(16'd100, 16'd75, 16'd25, 1'b0, 1'b1);
        check("full_after_5th", gif.req_ready, 0);
        fork
            push(16'd64, 16'd48, 16'd16, 1'b0, 1'b1);
            begin
                repeat (4) begin
                    @(negedge clk);
                    check("full_holds", gif.req_ready, 0);
                end
                step();
                gif.resp_ready = 1'b1;
            end
        join
        wait_drain("drain_backpressure");

        // Push lands in the same cycle IDLE pops the single queued entry.
        gif.resp_ready = 1'b0;
        push(16'd0, 16'd3, 16'd3, 1'b0, 1'b1);
        push(16'd0, 16'd4, 16'd4, 1'b0, 1'b1);
        gif.resp_ready = 1'b1;
        fork
            begin
                step();
                push(16'd0, 16'd5, 16'd5, 1'b0, 1'b1);
                @(negedge clk);
                check("concurrent_pop_gcd", gif.resp_gcd, 4);
            end
            begin
                repeat (5) begin
                    @(negedge clk);
                    check("concurrent_ready", gif.req_ready, 1);
                end
            end
        join
        wait_drain("drain_concurrent");

        // Reset during WAIT_DONE with a lingering Complete.
        eng_hang = 1'b1;
        push(16'd30, 16'd12, 16'd6, 1'b0, 1'b0);
        wait_begin("rst_job_begin");
        @(negedge clk);
        gif.Complete = 1'b1;
        gif.gcd      = 16'd6;
        rst          = 1'b1;
        #1;
        check("midrst_begin", gif.Begin, 0);
        check("midrst_a", gif.a, 0);
        check("midrst_b", gif.b, 0);
        check("midrst_resp_valid", gif.resp_valid, 0);
        check("midrst_resp_gcd", gif.resp_gcd, 0);
        check("midrst_resp_err", gif.resp_err, 0);
        check("midrst_req_ready", gif.req_ready, 1);
        @(negedge clk);
        rst           = 1'b0;
        gif.req_a     = 16'd21;
        gif.req_b     = 16'd14;
        gif.req_valid = 1'b1;
        sb.push_back('{gcd: 16'd7, err: 1'b0});
        n_expected++;
        step();
        gif.req_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("stale_complete_no_begin", gif.Begin, 0);
            check("stale_complete_no_pop", gif.a, 0);
        end
        gif.Complete = 1'b0;
        gif.gcd      = '0;
        eng_hang     = 1'b0;
        wait_begin("after_stale_begin");
        check("after_stale_a", gif.a, 21);
        wait_drain("drain_reset");

`ifdef GCD_MASTER_TIMEOUT_EN
        // Engine never answers: watchdog returns an error response.
        eng_hang = 1'b1;
        push(16'd9, 16'd3, 16'd0, 1'b1, 1'b1);
        wait_begin("timeout_begin");
        nw = 0;
        do begin
            @(negedge clk);
            nw++;
        end while (gif.resp_valid !== 1'b1 && nw < 200);
        check("timeout_cycles", nw, TO);
        wait_drain("drain_timeout");
        rst = 1'b1;
        step();
        rst      = 1'b0;
        eng_hang = 1'b0;
        step();
`endif

        check("resp_total", n_resp, n_expected);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gcd_master.md
# gcd_master

Initiator side of the GCD handshake (`Begin`/`a`/`b` out, `Complete`/`gcd` in). It queues operand pairs from a valid/ready request stream and issues them one at a time to the GCD engine. It captures each result and returns it on a valid/ready response stream in request order. It short-circuits zero operands, because the engine must never see a zero operand.

## Interface
- `WIDTH`, 16, operand and result width.
- `DEPTH`, 4, request queue entries; power of two, at least 2.
- `TIMEOUT_CYCLES`, 1024, watchdog limit in cycles; used only with `GCD_MASTER_TIMEOUT_EN`.
- `clk`  in  1  sole clock; all logic samples on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  queue can accept; equals `!full`.
- `req_a`, `req_b`  in  WIDTH  operand pair.
- `resp_valid`  out  1  result present.
- `resp_ready`  in  1  consumer accepts the result.
- `resp_gcd`  out  WIDTH  result.
- `resp_err`  out  1  watchdog expired for this result.
- `Begin`  out  1  one-cycle start pulse to the engine.
- `a`, `b`  out  WIDTH  operands to the engine; held stable from `Begin` until `Complete` falls.
- `Complete`  in  1  engine done; high for 2 consecutive cycles per job.
- `gcd`  in  WIDTH  engine result; valid only while `Complete` is high.

## Operation
- Queue:
  - Push on `req_valid && req_ready`.
  - Push and pop in the same cycle are both honoured when not full.
  - When full, a push is refused even if a pop occurs that cycle.
- FSM states: IDLE, ISSUE, WAIT_DONE, DRAIN, RESP.
- IDLE:
  - Pops when the queue is non-empty and `Complete == 0`. It never pops while `Complete` is high, which covers stale completions after reset.
  - Latches the pair into `a`/`b`.
  - If either operand is 0: `resp_gcd = a | b` (0 when both are 0), then go to RESP. No `Begin` is issued.
  - Otherwise go to ISSUE.
- ISSUE: `Begin = 1` for exactly this cycle, then go to WAIT_DONE.
- WAIT_DONE: on the first cycle with `Complete == 1`, register `gcd` into `resp_gcd` and go to DRAIN.
- DRAIN: wait for `Complete == 0`, then go to RESP. The engine's second `Complete` cycle is ignored.
- RESP:
  - `resp_valid = 1`; `resp_gcd` and `resp_err` are stable while `resp_valid` is high.
  - On `resp_ready`, go to IDLE.
- Only one job is in flight at a time. Responses are returned strictly in request order.
- Arithmetic: a zero test on each operand only. There are no width changes; `resp_gcd` is WIDTH bits.

## Timing
- Reset values:
  - `Begin` = 0, `a` = 0, `b` = 0.
  - `resp_valid` = 0, `resp_gcd` = 0, `resp_err` = 0.
  - Queue empty, so `req_ready` = 1. FSM in IDLE.
- Latency, non-zero pair, with the engine idle and the queue empty:
  - Push at edge N.
  - Pop in IDLE during cycle N+1.
  - `Begin` high during cycle N+2.
  - `resp_valid` rises 2 cycles after the cycle in which `Complete` first rose.
- Latency, zero-operand pair: `resp_valid` rises 2 cycles after the push edge.
- Back-to-back requests: the next pop happens in the cycle after the `resp_ready` handshake. Given a compliant engine, `Complete` is already 0 by then.
- Reset mid-operation: all state clears immediately, `Begin` drops, and queued requests are discarded. A lingering `Complete` is tolerated by the IDLE rule.

## Configuration
- `GCD_MASTER_TIMEOUT_EN` defined:
  - A counter runs in WAIT_DONE and DRAIN and clears on entry to ISSUE.
  - When it reaches `TIMEOUT_CYCLES`, go to RESP with `resp_gcd = 0` and `resp_err = 1`.
  - Recovering the engine after a timeout requires `rst`.
- `GCD_MASTER_TIMEOUT_EN` undefined:
  - No counter is built and `resp_err` is tied to 0.
  - WAIT_DONE and DRAIN wait indefinitely.

## Structure
- Shared package `gcd_pkg`: `GCD_WIDTH` = 16, state enum `gcd_master_state_t`, and a struct `gcd_req_t` holding {a, b}.
- Sub-module `gcd_req_fifo`:
  - Synchronous FIFO of `gcd_req_t`, `DEPTH` entries.
  - Wrap-around pointers with an extra MSB for full/empty.
  - Async active-high `rst`.

## Test plan
- Push (48, 18) with `resp_ready = 1` -> one `Begin` pulse, `a = 48`, `b = 18` stable until `Complete` falls; response `resp_gcd = 6`, `resp_err = 0`.
- Push (0, 7), then (0, 0) -> no `Begin`; responses 7 then 0, each with `resp_valid` rising 2 cycles after its push.
- `resp_ready = 0`, push 6 pairs (12,8), (9,6), (35,21), (17,5), (100,75), (64,48) -> `req_ready` falls after the 5th accept (1 in flight plus 4 queued). Then release `resp_ready` -> responses 4, 3, 7, 1, 25, 16 in that order.
- Push (0, 5) in the same cycle as a pop in IDLE with one entry queued -> no loss; `req_ready` stays 1 throughout.
- Assert `rst` during WAIT_DONE while the engine model holds `Complete` high for 2 more cycles -> outputs at reset values; the next request is not popped until `Complete` is 0.
- With `GCD_MASTER_TIMEOUT_EN` and `TIMEOUT_CYCLES = 64`, engine model never raises `Complete` -> 64 cycles after `Begin`, `resp_valid = 1`, `resp_err = 1`, `resp_gcd = 0`.
